// File: rtl/execute_muldiv_unit_if.sv
// EX-stage request/response bundle for the iterative multiply/divide unit.
// master = pipeline side driving operands, slave = the unit itself.
interface execute_muldiv_unit_if #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5
);
    logic               i_valid;
    logic [2:0]         i_md_op;
    logic [NB_DATA-1:0] i_RA;
    logic [NB_DATA-1:0] i_RB;
    logic [1:0]         i_corto_rs;
    logic [1:0]         i_corto_rt;
    logic [NB_DATA-1:0] i_input_ALU_MEM;
    logic [NB_DATA-1:0] i_output_WB;
    logic [NB_REG-1:0]  i_rd;
    logic               i_flush;
    logic               o_stall;
    logic               o_WB_write;
    logic [NB_REG-1:0]  o_write_reg;
    logic [NB_DATA-1:0] o_result;

    modport master (
        output i_valid, i_md_op, i_RA, i_RB, i_corto_rs, i_corto_rt,
               i_input_ALU_MEM, i_output_WB, i_rd, i_flush,
        input  o_stall, o_WB_write, o_write_reg, o_result
    );

    modport slave (
        input  i_valid, i_md_op, i_RA, i_RB, i_corto_rs, i_corto_rt,
               i_input_ALU_MEM, i_output_WB, i_rd, i_flush,
        output o_stall, o_WB_write, o_write_reg, o_result
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO, serving MFHI/MFLO.
// Works on operand magnitudes, one bit per cycle, and applies the sign fix on the last step.
module execute_muldiv_unit #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5
) (
    input logic                  i_clk,
    input logic                  i_reset_n,
    execute_muldiv_unit_if.slave bus
);
    localparam int unsigned NB_CNT = $clog2(NB_DATA);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e               state_q, state_d;
    logic [NB_CNT-1:0]    cnt_q;
    logic [NB_DATA-1:0]   m_q;
    logic [2*NB_DATA-1:0] acc_q;
    logic                 neg_q, rneg_q, dz_q;
    logic [NB_DATA-1:0]   dvd_q;
    logic [NB_DATA-1:0]   hi_q, lo_q;
    logic                 wb_q;
    logic [NB_REG-1:0]    wreg_q;
    logic [NB_DATA-1:0]   res_q;

    logic [NB_DATA-1:0]   op_a, op_b, a_mag, b_mag;
    logic                 is_signed, is_div, a_neg, b_neg, start, mf, busy, last;
    logic [NB_DATA:0]     mul_sum, div_shift;
    logic [NB_DATA-1:0]   div_sub, quot, rem, div_lo, div_hi;
    logic                 div_ge;
    logic [2*NB_DATA-1:0] mul_next, div_next, prod_fix;

    always_comb begin
        unique case (bus.i_corto_rs)
            2'b00:   op_a = bus.i_RA;
            2'b01:   op_a = bus.i_output_WB;
            2'b10:   op_a = bus.i_input_ALU_MEM;
            default: op_a = '0;
        endcase
        unique case (bus.i_corto_rt)
            2'b00:   op_b = bus.i_RB;
            2'b01:   op_b = bus.i_output_WB;
            2'b10:   op_b = bus.i_input_ALU_MEM;
            default: op_b = '0;
        endcase
        is_signed = (bus.i_md_op == OP_MULT) || (bus.i_md_op == OP_DIV);
        is_div    = (bus.i_md_op == OP_DIV) || (bus.i_md_op == OP_DIVU);
        a_neg     = is_signed & op_a[NB_DATA-1];
        b_neg     = is_signed & op_b[NB_DATA-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;
        busy      = (state_q != StIdle);
        start     = !busy && bus.i_valid && !bus.i_flush &&
                    (bus.i_md_op >= OP_MULT) && (bus.i_md_op <= OP_DIVU);
        mf        = !busy && bus.i_valid && !bus.i_flush &&
                    ((bus.i_md_op == OP_MFHI) || (bus.i_md_op == OP_MFLO));
        last      = (cnt_q == '0);
    end

    // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_next  = {mul_sum, acc_q[NB_DATA-1:1]};
        div_shift = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
        div_ge    = (div_shift >= {1'b0, m_q});
        div_sub   = div_shift[NB_DATA-1:0] - m_q;
        div_next  = {(div_ge ? div_sub : div_shift[NB_DATA-1:0]), acc_q[NB_DATA-2:0], div_ge};
        prod_fix  = neg_q ? -mul_next : mul_next;
        quot      = div_next[NB_DATA-1:0];
        rem       = div_next[2*NB_DATA-1:NB_DATA];
        div_lo    = dz_q ? '1 : (neg_q ? -quot : quot);
        div_hi    = dz_q ? dvd_q : (rneg_q ? -rem : rem);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:       if (start) state_d = is_div ? StDiv : StMul;
            StMul, StDiv: if (bus.i_flush || last) state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            dvd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            wb_q    <= 1'b0;
            wreg_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= mf;
            if (mf) begin
                res_q  <= (bus.i_md_op == OP_MFHI) ? hi_q : lo_q;
                wreg_q <= bus.i_rd;
            end
            if (start) begin
                cnt_q  <= NB_CNT'(NB_DATA - 1);
                m_q    <= is_div ? b_mag : a_mag;
                acc_q  <= {{NB_DATA{1'b0}}, (is_div ? a_mag : b_mag)};
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                dz_q   <= (op_b == '0);
                dvd_q  <= op_a;
            end else if (busy && !bus.i_flush) begin
                cnt_q <= cnt_q - 1'b1;
                acc_q <= (state_q == StMul) ? mul_next : div_next;
                if (last) begin
                    if (state_q == StMul) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else begin
                        hi_q <= div_hi;
                        lo_q <= div_lo;
                    end
                end
            end
        end
    end

    assign bus.o_stall     = (state_q != StIdle);
    assign bus.o_WB_write  = wb_q;
    assign bus.o_write_reg = wreg_q;
    assign bus.o_result    = res_q;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_execute_muldiv_unit;
    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_REG  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_muldiv_unit_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) bus ();

    execute_muldiv_unit #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_valid         = 1'b0;
        bus.i_md_op         = 3'd0;
        bus.i_RA            = '0;
        bus.i_RB            = '0;
        bus.i_corto_rs      = 2'b00;
        bus.i_corto_rt      = 2'b00;
        bus.i_input_ALU_MEM = '0;
        bus.i_output_WB     = '0;
        bus.i_rd            = '0;
        bus.i_flush         = 1'b0;
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] wb, input logic [31:0] mem);
        case (sel)
            2'b00:   return rf;
            2'b01:   return wb;
            2'b10:   return mem;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = sa * sb;
                {m_hi, m_lo} = p;
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
            end
            3'd3: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd4: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, count busy cycles (optionally driving junk meanwhile), update the model.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [31:0] mem, input logic [31:0] wb,
                          input logic [1:0] rs, input logic [1:0] rt, input bit noisy);
        int n;
        bit saw_wb;
        bus.i_valid = 1'b1;
        bus.i_md_op = op;
        bus.i_RA = ra;
        bus.i_RB = rb;
        bus.i_input_ALU_MEM = mem;
        bus.i_output_WB = wb;
        bus.i_corto_rs = rs;
        bus.i_corto_rt = rt;
        tick();
        idle_inputs();
        n = 0;
        saw_wb = 1'b0;
        while (bus.o_stall && n < 200) begin
            n++;
            if (bus.o_WB_write) saw_wb = 1'b1;
            if (noisy) begin
                bus.i_valid = 1'($urandom);
                bus.i_md_op = 3'($urandom_range(0, 7));
                bus.i_RA = $urandom;
                bus.i_RB = $urandom;
                bus.i_corto_rs = 2'($urandom);
                bus.i_corto_rt = 2'($urandom);
            end
            tick();
        end
        if (bus.o_WB_write) saw_wb = 1'b1;
        idle_inputs();
        check_eq({tag, "_stall_cycles"}, 64'(n), 64'd32);
        check_eq({tag, "_busy_wb"}, 64'(saw_wb), 64'd0);
        model_op(op, fwd(rs, ra, wb, mem), fwd(rt, rb, wb, mem));
    endtask

    task automatic read_mf(input string tag, input bit want_hi, input logic [4:0] rd);
        logic [31:0] exp;
        exp = want_hi ? m_hi : m_lo;
        bus.i_valid = 1'b1;
        bus.i_md_op = want_hi ? 3'd5 : 3'd6;
        bus.i_rd = rd;
        tick();
        idle_inputs();
        check_eq({tag, "_result"}, 64'(bus.o_result), 64'(exp));
        check_eq({tag, "_write_reg"}, 64'(bus.o_write_reg), 64'(rd));
        check_eq({tag, "_wb_on"}, 64'(bus.o_WB_write), 64'd1);
        tick();
        check_eq({tag, "_wb_off"}, 64'(bus.o_WB_write), 64'd0);
        check_eq({tag, "_hold"}, 64'(bus.o_result), 64'(exp));
    endtask

    initial begin
        logic [2:0] op;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_stall", 64'(bus.o_stall), 64'd0);
        check_eq("rst_wb", 64'(bus.o_WB_write), 64'd0);
        check_eq("rst_result", 64'(bus.o_result), 64'd0);
        check_eq("rst_write_reg", 64'(bus.o_write_reg), 64'd0);
        read_mf("rst_mfhi", 1'b1, 5'd3);

        // Multiply
        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 2'b00, 2'b00, 1'b0);
        read_mf("mult_hi", 1'b1, 5'd4);
        read_mf("mult_lo", 1'b0, 5'd5);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 0, 0, 2'b00, 2'b00, 1'b0);
        read_mf("multu_hi", 1'b1, 5'd6);
        read_mf("multu_lo", 1'b0, 5'd7);

        // Divide, including divide-by-zero and MIN / -1
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 2'b00, 2'b00, 1'b0);
        read_mf("div_lo", 1'b0, 5'd8);
        read_mf("div_hi", 1'b1, 5'd9);
        run_op("divu", 3'd4, 32'd7, 32'd2, 0, 0, 2'b00, 2'b00, 1'b0);
        read_mf("divu_lo", 1'b0, 5'd10);
        read_mf("divu_hi", 1'b1, 5'd11);
        run_op("div0", 3'd3, 32'd5, 32'd0, 0, 0, 2'b00, 2'b00, 1'b0);
        read_mf("div0_lo", 1'b0, 5'd12);
        read_mf("div0_hi", 1'b1, 5'd13);
        run_op("divmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 1'b0);
        read_mf("divmin_lo", 1'b0, 5'd14);
        read_mf("divmin_hi", 1'b1, 5'd15);

        // Forwarding selects
        run_op("fwd_mem", 3'd2, 32'd1, 32'd7, 32'd6, 32'd0, 2'b10, 2'b00, 1'b0);
        read_mf("fwd_mem_lo", 1'b0, 5'd16);
        run_op("fwd_wb", 3'd2, 32'd1, 32'd7, 32'd6, 32'd5, 2'b10, 2'b01, 1'b0);
        read_mf("fwd_wb_lo", 1'b0, 5'd17);

        // Reset in the middle of a MULT: no partial HI/LO update, everything cleared
        bus.i_valid = 1'b1;
        bus.i_md_op = 3'd1;
        bus.i_RA = 32'h1234_5678;
        bus.i_RB = 32'h9ABC_DEF0;
        tick();
        idle_inputs();
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("midrst_stall", 64'(bus.o_stall), 64'd0);
        check_eq("midrst_wb", 64'(bus.o_WB_write), 64'd0);
        check_eq("midrst_result", 64'(bus.o_result), 64'd0);
        m_hi = '0;
        m_lo = '0;
        read_mf("midrst_hi", 1'b1, 5'd18);
        read_mf("midrst_lo", 1'b0, 5'd19);

        // Flush: preload HI=LO=0x11, abort a MULTU in busy cycle 10
        run_op("preload", 3'd4, 32'h143, 32'h12, 0, 0, 2'b00, 2'b00, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_md_op = 3'd2;
        bus.i_RA = 32'd4;
        bus.i_RB = 32'd4;
        tick();
        idle_inputs();
        repeat (9) tick();
        check_eq("flush_busy_before", 64'(bus.o_stall), 64'd1);
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_md_op = 3'd1;
        tick();
        idle_inputs();
        check_eq("flush_stall", 64'(bus.o_stall), 64'd0);
        read_mf("flush_lo", 1'b0, 5'd20);
        read_mf("flush_hi", 1'b1, 5'd21);
        // Flush while idle drops an MF* and a start presented alongside it
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_md_op = 3'd6;
        bus.i_rd = 5'd22;
        tick();
        check_eq("flush_mf_wb", 64'(bus.o_WB_write), 64'd0);
        bus.i_md_op = 3'd2;
        tick();
        idle_inputs();
        check_eq("flush_start_stall", 64'(bus.o_stall), 64'd0);

        // Back-to-back: MFLO in the first idle cycle after completion
        run_op("b2b", 3'd2, 32'd2, 32'd3, 0, 0, 2'b00, 2'b00, 1'b0);
        read_mf("b2b_lo", 1'b0, 5'd23);

        // Randomized ops with junk driven while busy
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(1, 4));
            run_op("rnd", op, rand_word(), rand_word(), rand_word(), rand_word(),
                   2'($urandom), 2'($urandom), 1'b1);
            read_mf("rnd_hi", 1'b1, 5'($urandom));
            read_mf("rnd_lo", 1'b0, 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
